// File: rtl/flex_counter_pkg.sv
// flex_counter_pkg
//   Shared types and constants for the flex_counter_v2 family.
//   cnt_mode_t : behaviour at a terminal value (wrap around or saturate).
//   DIR_DOWN / DIR_UP : encoding of the dir input.
package flex_counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/flex_prescaler.sv
// flex_prescaler
//   Divides enabled cycles by (prescale_val + 1) and emits a combinational tick
//   in the enabled cycle where the prescaler sits at its terminal value.
// Ports
//   clk           in  rising-edge clock
//   rst           in  synchronous active-high reset
//   clear         in  synchronous restart of the prescaler (clear or load)
//   count_enable  in  advance the prescaler this cycle
//   prescale_val  in  terminal value of the prescaler
//   tick          out 1 in the enabled cycle that reaches the terminal value
module flex_prescaler #(
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     count_enable,
    input  logic [PRESCALE_BITS-1:0] prescale_val,
    output logic                     tick
);

    logic [PRESCALE_BITS-1:0] psc;

    // '>=' rather than '==' so that lowering prescale_val below the current
    // prescaler value mid-run still terminates the period immediately.
    assign tick = count_enable && (psc >= prescale_val);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            psc <= '0;
        end else if (count_enable) begin
            if (tick) begin
                psc <= '0;
            end else begin
                psc <= psc + PRESCALE_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/flex_counter_v2.sv
// flex_counter_v2
//   Up/down counter over 0..rollover_val with wrap or saturate behaviour,
//   parallel load and a built-in prescaler. All outputs are registered.
//   Per-cycle priority: rst > clear > load > tick > hold.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   clear          synchronous clear of count, prescaler and all flags
//   count_enable   advance the prescaler this cycle
//   dir            1 = up, 0 = down
//   mode           0 = CNT_WRAP, 1 = CNT_SAT
//   load, load_val parallel load of the count (values above rollover_val kept)
//   rollover_val   terminal value of the count
//   prescale_val   count moves every prescale_val+1 enabled cycles
//   count_out      registered count
//   rollover_flag  one-cycle pulse in the cycle count_out shows a wrapped value
//   sat_flag       high while the count is held at a limit in CNT_SAT
//   ovf_sticky     set on any wrap or saturation, cleared by clear/rst
module flex_counter_v2
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS  = 8,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     count_enable,
    input  logic                     dir,
    input  logic                     mode,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    input  logic [PRESCALE_BITS-1:0] prescale_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     sat_flag,
    output logic                     ovf_sticky
);

    cnt_mode_t                mode_e;
    logic                     tick;
    logic [NUM_CNT_BITS-1:0]  cnt_nxt;
    logic                     rf_nxt;
    logic                     sat_nxt;
    logic                     ovf_nxt;
    logic                     at_top;
    logic                     at_zero;
    logic                     above_top;

    assign mode_e = cnt_mode_t'(mode);

    flex_prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_prescaler (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear | load),
        .count_enable (count_enable),
        .prescale_val (prescale_val),
        .tick         (tick)
    );

    // Limits are compared before any +/-1, so the count never wraps modulo
    // 2**NUM_CNT_BITS.
    assign at_top    = (count_out >= rollover_val);
    assign above_top = (count_out > rollover_val);
    assign at_zero   = (count_out == '0);

    always_comb begin
        cnt_nxt = count_out;
        rf_nxt  = 1'b0;
        sat_nxt = sat_flag;
        ovf_nxt = ovf_sticky;
        if (clear) begin
            cnt_nxt = '0;
            sat_nxt = 1'b0;
            ovf_nxt = 1'b0;
        end else if (load) begin
            cnt_nxt = load_val;
            sat_nxt = 1'b0;
        end else if (tick) begin
            case (dir)
                DIR_UP: begin
                    if (!at_top) begin
                        cnt_nxt = count_out + NUM_CNT_BITS'(1);
                        sat_nxt = 1'b0;
                    end else if (mode_e == CNT_WRAP) begin
                        cnt_nxt = '0;
                        rf_nxt  = 1'b1;
                        ovf_nxt = 1'b1;
                        // With rollover_val==0 the wrap leaves the count at 0,
                        // so sat_flag is not disturbed.
                        if (!at_zero) sat_nxt = 1'b0;
                    end else begin
                        cnt_nxt = rollover_val;
                        sat_nxt = 1'b1;
                        ovf_nxt = 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (above_top) begin
                        // Out-of-range loaded value: snap to the terminal value.
                        cnt_nxt = rollover_val;
                        sat_nxt = 1'b0;
                    end else if (!at_zero) begin
                        cnt_nxt = count_out - NUM_CNT_BITS'(1);
                        sat_nxt = 1'b0;
                    end else if (mode_e == CNT_WRAP) begin
                        cnt_nxt = rollover_val;
                        rf_nxt  = 1'b1;
                        ovf_nxt = 1'b1;
                        if (rollover_val != '0) sat_nxt = 1'b0;
                    end else begin
                        sat_nxt = 1'b1;
                        ovf_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            sat_flag      <= 1'b0;
            ovf_sticky    <= 1'b0;
        end else begin
            count_out     <= cnt_nxt;
            rollover_flag <= rf_nxt;
            sat_flag      <= sat_nxt;
            ovf_sticky    <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_flex_counter_v2.sv
// tb_flex_counter_v2
//   Drives three flex_counter_v2 instances (8, 1 and 16 count bits) with shared
//   control and checks every cycle against a reference model computed from the
//   counting rules, plus directed expectations for the documented scenarios.
module tb_flex_counter_v2;
    import flex_counter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        ce = 1'b0;
    logic        dir = DIR_UP;
    logic        mode = CNT_WRAP;
    logic        load = 1'b0;
    logic [15:0] lv = '0;
    logic [15:0] rv = '0;
    logic [3:0]  pv = '0;

    logic [7:0]  co8;
    logic [0:0]  co1;
    logic [15:0] co16;
    logic        rf8, rf1, rf16;
    logic        sat8, sat1, sat16;
    logic        ovf8, ovf1, ovf16;

    flex_counter_v2 #(.NUM_CNT_BITS(8), .PRESCALE_BITS(4)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .count_enable(ce), .dir(dir),
        .mode(mode), .load(load), .load_val(lv[7:0]), .rollover_val(rv[7:0]),
        .prescale_val(pv), .count_out(co8), .rollover_flag(rf8),
        .sat_flag(sat8), .ovf_sticky(ovf8)
    );

    flex_counter_v2 #(.NUM_CNT_BITS(1), .PRESCALE_BITS(4)) u_w1 (
        .clk(clk), .rst(rst), .clear(clear), .count_enable(ce), .dir(dir),
        .mode(mode), .load(load), .load_val(lv[0:0]), .rollover_val(rv[0:0]),
        .prescale_val(pv), .count_out(co1), .rollover_flag(rf1),
        .sat_flag(sat1), .ovf_sticky(ovf1)
    );

    flex_counter_v2 #(.NUM_CNT_BITS(16), .PRESCALE_BITS(4)) u_w16 (
        .clk(clk), .rst(rst), .clear(clear), .count_enable(ce), .dir(dir),
        .mode(mode), .load(load), .load_val(lv), .rollover_val(rv),
        .prescale_val(pv), .count_out(co16), .rollover_flag(rf16),
        .sat_flag(sat16), .ovf_sticky(ovf16)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per-instance state as plain integers; the prescaler is common to all.
    int widths[3] = '{8, 1, 16};
    int m_cnt[3];
    int m_rf[3];
    int m_sat[3];
    int m_ovf[3];
    int m_psc = 0;

    task automatic model_step();
        bit tick;
        tick = ce && (m_psc >= int'(pv));
        for (int k = 0; k < 3; k++) begin
            int mask, r, c, nc, set_rf, set_sat;
            mask = (1 << widths[k]) - 1;
            r = int'(rv) & mask;
            c = m_cnt[k];
            if (rst || clear) begin
                m_cnt[k] = 0; m_rf[k] = 0; m_sat[k] = 0; m_ovf[k] = 0;
            end else if (load) begin
                m_cnt[k] = int'(lv) & mask; m_rf[k] = 0; m_sat[k] = 0;
            end else begin
                m_rf[k] = 0;
                if (tick) begin
                    nc = c; set_rf = 0; set_sat = 0;
                    if (dir == DIR_UP) begin
                        if (c < r) nc = c + 1;
                        else if (mode == CNT_WRAP) begin nc = 0; set_rf = 1; end
                        else begin nc = r; set_sat = 1; end
                    end else begin
                        if (c > r) nc = r;
                        else if (c > 0) nc = c - 1;
                        else if (mode == CNT_WRAP) begin nc = r; set_rf = 1; end
                        else set_sat = 1;
                    end
                    if (set_sat) m_sat[k] = 1;
                    else if (nc != c) m_sat[k] = 0;
                    m_rf[k] = set_rf;
                    if (set_rf || set_sat) m_ovf[k] = 1;
                    m_cnt[k] = nc;
                end
            end
        end
        if (rst || clear || load) m_psc = 0;
        else if (ce) m_psc = tick ? 0 : m_psc + 1;
    endtask

    task automatic check_model();
        check("w8_cnt",  co8,  m_cnt[0]);
        check("w8_rf",   rf8,  m_rf[0]);
        check("w8_sat",  sat8, m_sat[0]);
        check("w8_ovf",  ovf8, m_ovf[0]);
        check("w1_cnt",  co1,  m_cnt[1]);
        check("w1_rf",   rf1,  m_rf[1]);
        check("w1_sat",  sat1, m_sat[1]);
        check("w1_ovf",  ovf1, m_ovf[1]);
        check("w16_cnt", co16, m_cnt[2]);
        check("w16_rf",  rf16, m_rf[2]);
        check("w16_sat", sat16, m_sat[2]);
        check("w16_ovf", ovf16, m_ovf[2]);
    endtask

    // ---------------- driver ----------------
    // Inputs are changed 1 time unit after a rising edge and stay stable over
    // the next edge; outputs are compared 1 time unit after that edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        cycles(2);
        check("reset_cnt", co8, 0);
        check("reset_ovf", ovf8, 0);
        rst = 1'b0;

        // 1: reset mid-count at count=5, psc=2
        dir = DIR_UP; mode = CNT_WRAP; rv = 16'd20; pv = 4'd3; ce = 1'b1;
        cycles(22);
        check("t1_pre_cnt", co8, 5);
        rst = 1'b1;
        cycle();
        check("t1_rst_cnt", co8, 0);
        cycles(2);
        check("t1_rst_hold_cnt", co8, 0);
        rst = 1'b0; ce = 1'b0;
        cycle();

        // 2: up, wrap, rollover_val=3, tick every enabled cycle
        rv = 16'd3; pv = 4'd0; ce = 1'b1;
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2};
        for (int i = 0; i < 10; i++) begin
            logic [15:0] e;
            cycle();
            e = exp_q.pop_front();
            check("t2_seq_cnt", co8, e);
            check("t2_seq_rf", rf8, (e == 16'd0));
        end
        check("t2_ovf", ovf8, 1);

        // 3: down, saturate, load 2, prescale 2
        ce = 1'b0; load = 1'b1; lv = 16'd2; rv = 16'd10;
        dir = DIR_DOWN; mode = CNT_SAT; pv = 4'd2;
        cycle();
        load = 1'b0; ce = 1'b1;
        cycles(3);
        check("t3_c3", co8, 1);
        cycles(3);
        check("t3_c6", co8, 0);
        cycles(2);
        check("t3_c8_sat", sat8, 0);
        cycle();
        check("t3_c9_sat", sat8, 1);
        cycles(3);
        dir = DIR_UP;
        cycles(3);
        check("t3_up_cnt", co8, 1);
        check("t3_up_sat", sat8, 0);

        // 4: clear beats load; out-of-range load then wrap
        ce = 1'b0; mode = CNT_WRAP; load = 1'b1; clear = 1'b1; lv = 16'd9;
        cycle();
        check("t4_clear_wins", co8, 0);
        clear = 1'b0; rv = 16'd5; pv = 4'd0;
        cycle();
        check("t4_load", co8, 9);
        load = 1'b0; ce = 1'b1;
        cycle();
        check("t4_wrap_cnt", co8, 0);
        check("t4_wrap_rf", rf8, 1);

        // 5: enable dropped at psc=1, count=2
        ce = 1'b0; clear = 1'b1;
        cycle();
        clear = 1'b0; ce = 1'b1; pv = 4'd3; rv = 16'd50; dir = DIR_UP;
        cycles(9);
        check("t5_pre", co8, 2);
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t5_hold_cnt", co8, 2);
            check("t5_hold_rf", rf8, 0);
        end
        ce = 1'b1;
        cycles(2);
        check("t5_resume_early", co8, 2);
        cycle();
        check("t5_resume_tick", co8, 3);

        // Randomised run against the model
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            clear = ($urandom_range(0, 31) == 0);
            load  = ($urandom_range(0, 15) == 0);
            ce    = ($urandom_range(0, 3) != 0);
            dir   = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) mode = $urandom_range(0, 1);
            lv    = $urandom_range(0, 65535);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0: rv = 16'd0;
                    1: rv = $urandom_range(0, 7);
                    default: rv = $urandom_range(0, 65535);
                endcase
            end
            if ($urandom_range(0, 15) == 0) pv = $urandom_range(0, 3);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
